regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: requester 0 is ALU writeback and requester 1 is load writeback. Each requester has its own small FIFO, and a round-robin arbiter drains one entry per cycle onto the regfile write/write_address/write_data inputs. The block also sequences end of run: a halt request drains all queued writes, then raises complete, which triggers the regfile dump.

Parameters:
DATA_WIDTH, 16, register data width
ADDR_WIDTH, 3, register address width
NUM_REGS, 8, number of registers; equals 2**ADDR_WIDTH
FIFO_DEPTH, 2, entries per requester queue; power of two, at least 2

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a write to offer
req0_ready  output  1  requester 0 write accepted this cycle if valid is also high
req0_address  input  ADDR_WIDTH  requester 0 destination register
req0_data  input  DATA_WIDTH  requester 0 write data
req1_valid  input  1  requester 1 has a write to offer
req1_ready  output  1  requester 1 write accepted this cycle if valid is also high
req1_address  input  ADDR_WIDTH  requester 1 destination register
req1_data  input  DATA_WIDTH  requester 1 write data
halt  input  1  single-cycle pulse requesting end of run
write  output  1  regfile write enable
write_address  output  ADDR_WIDTH  regfile write address
write_data  output  DATA_WIDTH  regfile write data
complete  output  1  all writes retired; drives the regfile complete input
pending  output  NUM_REGS  bit i set while any queued entry targets register i
idle  output  1  both queues empty and write low

Behaviour:
- Reset (asynchronous, active-high):
  - both queues flushed; state RUN
  - round-robin pointer set so requester 0 wins the first contention
  - write=0, write_address=0, write_data=0, complete=0
  - pending=0, idle=1
  - reset mid-drain or in DONE returns to RUN and discards queued writes
- Handshake:
  - reqN_ready = (queue N not full) and (state == RUN); ready is combinational from registered state only
  - a push occurs on a rising edge with reqN_valid && reqN_ready
  - a full queue does not accept in the same cycle it pops; ready is low for that whole cycle
  - valid asserted while ready is low is ignored; the requester holds valid and data
- Queues:
  - FIFO per requester; entries {address, data}
  - circular read/write pointers with an extra wrap bit
  - full when the pointers differ only in the wrap bit
  - push and pop in the same cycle on a non-full, non-empty queue keeps the count unchanged
- Arbitration, once per cycle:
  - if only one queue is non-empty, grant it
  - if both are non-empty, grant the queue not granted last; update the pointer on grant only
  - the granted head is popped on the edge and loaded into the output registers: write=1, write_address, write_data
  - with no grant, write=0 and address/data hold their last values
- Latency: a write pushed at edge N reaches the output no earlier than edge N+1, visible as write=1 during cycle N+1. Throughput is one write per cycle total.
- Ordering: FIFO order within a requester. No ordering between requesters; same-address conflicts are the issuer's responsibility, which pending exposes.
- pending: OR of one-hot(address) over all valid entries of both queues. Combinational from queue state. The output-stage entry is excluded.
- State machine:
  - RUN: accept and arbitrate. halt=1 -> DRAIN; entries pushed on the same edge as halt are kept.
  - DRAIN: ready=0; keep arbitrating. Both queues empty and write=0 -> DONE on the next edge.
  - DONE: complete=1, held until reset; ready=0; write=0; further halt pulses ignored.
  - halt while already in DRAIN has no effect.
- idle is combinational: both queues empty && write==0.

Test Plan:
- Single write: req0 pushes r3=16'h1234 at edge 1 -> write=1, write_address=3, write_data=16'h1234 during cycle 2 only; pending[3]=1 during cycle 1→2 interval, then 0.
- Contention: both valid every cycle with req0 writing r1=16'hA000+k and req1 writing r2=16'hB000+k -> writes alternate req0, req1, req0 and so on, one per cycle; no entry lost or duplicated.
- Backpressure: req1 pushes 3 entries with FIFO_DEPTH=2 while req0 keeps its queue non-empty -> req1_ready drops after 2 pushes; the third entry is accepted only after a pop; order is preserved.
- Halt drain: 2 entries in each queue, then halt pulse -> ready=0 the next cycle; exactly 4 writes occur; complete rises 1 cycle after the last write=1 and stays high.
- Reset mid-drain: assert reset with 2 queued entries during DRAIN -> write=0 and complete=0 immediately; pending=0; after release, ready=1 and no stale writes appear.
- Pending mask: queue r0 and r7 in q0 and r7 in q1 -> pending=8'h81; after the two r7 writes retire, pending=8'h01.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, halt and regfile write-port signals shared between
// the writeback requesters and the regfile write arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REGS   = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_address;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_address;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  halt;
  logic                  write;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  complete;
  logic [NUM_REGS-1:0]   pending;
  logic                  idle;

  modport master (
    output req0_valid, req0_address, req0_data,
    output req1_valid, req1_address, req1_data,
    output halt,
    input  req0_ready, req1_ready,
    input  write, write_address, write_data, complete, pending, idle
  );

  modport slave (
    input  req0_valid, req0_address, req0_data,
    input  req1_valid, req1_address, req1_data,
    input  halt,
    output req0_ready, req1_ready,
    output write, write_address, write_data, complete, pending, idle
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two queued writeback requesters (ALU, load) round-robin arbitrated onto
// the single regfile write port, with halt -> drain -> complete sequencing.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                state_q;
  logic                  last_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  complete_q;

  entry_t                mem_q  [2][FIFO_DEPTH];
  logic [CNT_W-1:0]      wptr_q [2];
  logic [CNT_W-1:0]      rptr_q [2];

  logic [1:0]            empty;
  logic [1:0]            full;
  logic [1:0]            ready;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            req_valid;
  entry_t                push_entry [2];
  logic                  gnt_any;
  logic                  gnt_sel;
  entry_t                head;
  logic [CNT_W-1:0]      count [2];
  logic [PTR_W-1:0]      slot;
  logic [NUM_REGS-1:0]   pending;

  // Queue status, handshake and round-robin grant
  always_comb begin
    req_valid     = {bus.req1_valid, bus.req0_valid};
    push_entry[0] = '{addr: bus.req0_address, data: bus.req0_data};
    push_entry[1] = '{addr: bus.req1_address, data: bus.req1_data};
    for (int r = 0; r < 2; r++) begin
      empty[r] = (wptr_q[r] == rptr_q[r]);
      full[r]  = (wptr_q[r][PTR_W] != rptr_q[r][PTR_W]) &&
                 (wptr_q[r][PTR_W-1:0] == rptr_q[r][PTR_W-1:0]);
      ready[r] = !full[r] && (state_q == ST_RUN);
      push[r]  = req_valid[r] && ready[r];
      count[r] = wptr_q[r] - rptr_q[r];
    end
    gnt_any = !empty[0] || !empty[1];
    // Requester 1 wins when it is the only one waiting or requester 0 went last
    gnt_sel = !empty[1] && (empty[0] || !last_q);
    pop[0]  = gnt_any && !gnt_sel;
    pop[1]  = gnt_any && gnt_sel;
    head    = mem_q[gnt_sel][rptr_q[gnt_sel][PTR_W-1:0]];
  end

  // Destination mask of every entry still sitting in either queue
  always_comb begin
    pending = '0;
    slot    = '0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
        if (CNT_W'(k) < count[r]) begin
          slot = rptr_q[r][PTR_W-1:0] + PTR_W'(k);
          pending[mem_q[r][slot].addr] = 1'b1;
        end
      end
    end
  end

  // Queue storage carries no reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        mem_q[r][wptr_q[r][PTR_W-1:0]] <= push_entry[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      last_q     <= 1'b1;
      write_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      complete_q <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        wptr_q[r] <= '0;
        rptr_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) wptr_q[r] <= wptr_q[r] + CNT_W'(1);
        if (pop[r])  rptr_q[r] <= rptr_q[r] + CNT_W'(1);
      end
      if (gnt_any) begin
        last_q  <= gnt_sel;
        write_q <= 1'b1;
        waddr_q <= head.addr;
        wdata_q <= head.data;
      end else begin
        write_q <= 1'b0;
      end
      case (state_q)
        ST_RUN: begin
          if (bus.halt) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (empty[0] && empty[1] && !write_q) begin
            state_q    <= ST_DONE;
            complete_q <= 1'b1;
          end
        end
        ST_DONE: begin
          complete_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.req0_ready    = ready[0];
  assign bus.req1_ready    = ready[1];
  assign bus.write         = write_q;
  assign bus.write_address = waddr_q;
  assign bus.write_data    = wdata_q;
  assign bus.complete      = complete_q;
  assign bus.pending       = pending;
  assign bus.idle          = empty[0] && empty[1] && !write_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: single write, contention,
// backpressure, halt drain, reset during drain and the pending mask.
module tb_regfile_write_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [DW-1:0] exp_d [8];
  logic [AW-1:0] exp_a [8];

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid   = 1'b0;
    bus.req0_address = '0;
    bus.req0_data    = '0;
    bus.req1_valid   = 1'b0;
    bus.req1_address = '0;
    bus.req1_data    = '0;
    bus.halt         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // req0 always offers r1=A000+k; req1 offers a1=b1+k until lim1 accepted
  task automatic run_traffic(input int lim1, input logic [AW-1:0] a1,
                             input logic [DW-1:0] b1, input string nm);
    int   k0 = 0;
    int   k1 = 0;
    logic r0;
    logic r1;
    for (int c = 0; c <= 9; c++) begin
      bus.req0_valid   = 1'b1;
      bus.req0_address = 3'd1;
      bus.req0_data    = 16'hA000 + DW'(k0);
      bus.req1_valid   = (k1 < lim1);
      bus.req1_address = a1;
      bus.req1_data    = b1 + DW'(k1);
      if (c >= 1 && c <= 3)
        check($sformatf("%s_rdy1_c%0d", nm, c), 32'(bus.req1_ready), (c == 2) ? 32'd0 : 32'd1);
      if (c == 1) check($sformatf("%s_lat", nm), 32'(bus.write), 32'd0);
      if (c >= 2) begin
        check($sformatf("%s_we_c%0d", nm, c), 32'(bus.write), 32'd1);
        check($sformatf("%s_wa_c%0d", nm, c), 32'(bus.write_address), 32'(exp_a[c-2]));
        check($sformatf("%s_wd_c%0d", nm, c), 32'(bus.write_data), 32'(exp_d[c-2]));
      end
      r0 = bus.req0_ready;
      r1 = bus.req1_ready && bus.req1_valid;
      if (c < 9) begin
        step();
        if (r0) k0++;
        if (r1) k1++;
      end
    end
    idle_inputs();
  endtask

  // Both queues loaded on edge 1, second entries and halt on edge 2
  task automatic load_and_halt();
    bus.req0_valid = 1'b1; bus.req0_address = 3'd1; bus.req0_data = 16'hA000;
    bus.req1_valid = 1'b1; bus.req1_address = 3'd2; bus.req1_data = 16'hB000;
    step();
    bus.req0_data = 16'hA001;
    bus.req1_data = 16'hB001;
    bus.halt      = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    do_reset();

    check("rst_write",    32'(bus.write), 32'd0);
    check("rst_complete", 32'(bus.complete), 32'd0);
    check("rst_pending",  32'(bus.pending), 32'd0);
    check("rst_idle",     32'(bus.idle), 32'd1);
    check("rst_rdy0",     32'(bus.req0_ready), 32'd1);
    check("rst_rdy1",     32'(bus.req1_ready), 32'd1);
    check("rst_waddr",    32'(bus.write_address), 32'd0);

    // Single write
    bus.req0_valid = 1'b1; bus.req0_address = 3'd3; bus.req0_data = 16'h1234;
    step();
    idle_inputs();
    check("single_pend1", 32'(bus.pending), 32'h08);
    check("single_we1",   32'(bus.write), 32'd0);
    check("single_idle1", 32'(bus.idle), 32'd0);
    step();
    check("single_we2",   32'(bus.write), 32'd1);
    check("single_wa2",   32'(bus.write_address), 32'd3);
    check("single_wd2",   32'(bus.write_data), 32'h1234);
    check("single_pend2", 32'(bus.pending), 32'h00);
    step();
    check("single_we3",   32'(bus.write), 32'd0);
    check("single_hold3", 32'(bus.write_address), 32'd3);
    check("single_idle3", 32'(bus.idle), 32'd1);

    // Contention: strict alternation starting with requester 0
    do_reset();
    exp_d = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002, 16'hA003, 16'hB003};
    exp_a = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2};
    run_traffic(100, 3'd2, 16'hB000, "cont");

    // Backpressure: third req1 entry waits for a pop, order kept
    do_reset();
    exp_d = '{16'hA000, 16'hD000, 16'hA001, 16'hD001, 16'hA002, 16'hD002, 16'hA003, 16'hA004};
    exp_a = '{3'd1, 3'd5, 3'd1, 3'd5, 3'd1, 3'd5, 3'd1, 3'd1};
    run_traffic(3, 3'd5, 16'hD000, "bp");

    // Halt drain
    do_reset();
    load_and_halt();
    check("drain_rdy0", 32'(bus.req0_ready), 32'd0);
    check("drain_rdy1", 32'(bus.req1_ready), 32'd0);
    exp_d = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check($sformatf("drain_we%0d", i), 32'(bus.write), 32'd1);
      check($sformatf("drain_wd%0d", i), 32'(bus.write_data), 32'(exp_d[i]));
      check($sformatf("drain_cpl%0d", i), 32'(bus.complete), 32'd0);
    end
    step();
    check("drain_we_end", 32'(bus.write), 32'd0);
    check("drain_idle",   32'(bus.idle), 32'd1);
    step();
    check("done_cpl",  32'(bus.complete), 32'd1);
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    check("done_cpl_hold", 32'(bus.complete), 32'd1);
    check("done_we",       32'(bus.write), 32'd0);
    check("done_rdy0",     32'(bus.req0_ready), 32'd0);
    step();
    check("done_cpl_hold2", 32'(bus.complete), 32'd1);

    // Reset while draining with two entries still queued
    do_reset();
    load_and_halt();
    step();
    check("rmd_we_pre",   32'(bus.write), 32'd1);
    check("rmd_pend_pre", 32'(bus.pending), 32'h06);
    #2;
    reset = 1'b1;
    #1;
    check("rmd_we",   32'(bus.write), 32'd0);
    check("rmd_cpl",  32'(bus.complete), 32'd0);
    check("rmd_pend", 32'(bus.pending), 32'h00);
    check("rmd_idle", 32'(bus.idle), 32'd1);
    #1;
    reset = 1'b0;
    step();
    check("rmd_rdy0", 32'(bus.req0_ready), 32'd1);
    check("rmd_rdy1", 32'(bus.req1_ready), 32'd1);
    check("rmd_we1",  32'(bus.write), 32'd0);
    step();
    check("rmd_we2",  32'(bus.write), 32'd0);

    // Pending mask across both queues
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_address = 3'd7; bus.req0_data = 16'h0070;
    bus.req1_valid = 1'b1; bus.req1_address = 3'd7; bus.req1_data = 16'h0071;
    step();
    check("pend_c1", 32'(bus.pending), 32'h80);
    bus.req0_address = 3'd0; bus.req0_data = 16'h0000;
    bus.req1_valid   = 1'b0;
    step();
    idle_inputs();
    check("pend_c2",  32'(bus.pending), 32'h81);
    check("pend_wa2", 32'(bus.write_address), 32'd7);
    step();
    check("pend_c3",  32'(bus.pending), 32'h01);
    check("pend_wa3", 32'(bus.write_address), 32'd7);
    check("pend_wd3", 32'(bus.write_data), 32'h0071);
    step();
    check("pend_c4",  32'(bus.pending), 32'h00);
    check("pend_wa4", 32'(bus.write_address), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
